// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   state_t     : controller state encoding (RUN / MEM_WAIT / ERROR)
//   REG_ZERO    : architectural x0 register index
//   en_bundle_t : stage write enables ordered {PC, IF_ID, ID_EX, EX_MEM, MEM_WB}
package pipe_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc;
      logic if_id;
      logic id_ex;
      logic ex_mem;
      logic mem_wb;
   } en_bundle_t;

   localparam en_bundle_t EN_ALL  = 5'b11111;
   localparam en_bundle_t EN_NONE = 5'b00000;

   // Branch resolved in MEM is taken when the compare produced zero.
   function automatic logic branch_taken(input logic branch, input logic zero);
      return branch & zero;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
//   Inputs to controller : hazard operands from ID/EX, branch and memory-op
//                          flags from MEM, dmem_ack handshake completion.
//   Outputs              : dmem_req, stage write enables, flush strobes,
//                          timeout_err and the stall_cycles counter.
//   master modport : pipeline / memory side; slave modport : controller.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             MemRead_EX;
   logic [4:0]       RD_EX;
   logic [4:0]       RS1_ID;
   logic [4:0]       RS2_ID;
   logic             Branch_MEM;
   logic             ZERO_MEM;
   logic             MemRead_MEM;
   logic             MemWrite_MEM;
   logic             dmem_ack;
   logic             dmem_req;
   logic             PC_write;
   logic             IF_ID_write;
   logic             ID_EX_write;
   logic             EX_MEM_write;
   logic             MEM_WB_write;
   logic             IF_ID_flush;
   logic             ID_EX_flush;
   logic             EX_MEM_flush;
   logic             timeout_err;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output MemRead_EX, RD_EX, RS1_ID, RS2_ID, Branch_MEM, ZERO_MEM,
             MemRead_MEM, MemWrite_MEM, dmem_ack,
      input  dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             MEM_WB_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
             timeout_err, stall_cycles
   );

   modport slave (
      input  MemRead_EX, RD_EX, RS1_ID, RS2_ID, Branch_MEM, ZERO_MEM,
             MemRead_MEM, MemWrite_MEM, dmem_ack,
      output dmem_req, PC_write, IF_ID_write, ID_EX_write, EX_MEM_write,
             MEM_WB_write, IF_ID_flush, ID_EX_flush, EX_MEM_flush,
             timeout_err, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare (purely combinational).
//   MemRead_EX, RD_EX : load in EX and its destination
//   RS1_ID, RS2_ID    : sources of the instruction in ID
//   hazard            : ID instruction needs the load result next cycle
module hazard_detect
   import pipe_pkg::*;
(
   input  logic       MemRead_EX,
   input  logic [4:0] RD_EX,
   input  logic [4:0] RS1_ID,
   input  logic [4:0] RS2_ID,
   output logic       hazard
);
   // x0 is hardwired to zero, so a load into it never creates a dependency.
   assign hazard = MemRead_EX & (RD_EX != REG_ZERO) &
                   ((RD_EX == RS1_ID) | (RD_EX == RS2_ID));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//   clk   : pipeline clock
//   reset : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (hazard inputs, dmem handshake,
//           stage enables, flushes, timeout_err, stall_cycles)
// Priority in RUN: memory stall > branch flush > load-use bubble.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic                clk,
   input  logic                reset,
   pipe_hazard_ctrl_if.slave   bus
);
   localparam int WCNT_W = $clog2(TIMEOUT + 1);

   state_t            state_r, state_nxt_s;
   logic [WCNT_W-1:0] wcnt_r, wcnt_nxt_s;
   logic              timeout_err_r, timeout_err_nxt_s;
   logic [CNT_W-1:0]  stall_cycles_r;

   en_bundle_t        en_s;
   logic              req_s, if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;
   logic              hazard_s, mem_op_s, taken_s;

   hazard_detect u_hazard_detect (
      .MemRead_EX (bus.MemRead_EX),
      .RD_EX      (bus.RD_EX),
      .RS1_ID     (bus.RS1_ID),
      .RS2_ID     (bus.RS2_ID),
      .hazard     (hazard_s)
   );

   assign mem_op_s = bus.MemRead_MEM | bus.MemWrite_MEM;
   assign taken_s  = branch_taken(bus.Branch_MEM, bus.ZERO_MEM);

   // Next-state and combinational stage controls; everything is forced low while reset is held.
   always_comb begin
      state_nxt_s       = state_r;
      wcnt_nxt_s        = wcnt_r;
      timeout_err_nxt_s = timeout_err_r;
      en_s              = EN_NONE;
      req_s             = 1'b0;
      if_id_flush_s     = 1'b0;
      id_ex_flush_s     = 1'b0;
      ex_mem_flush_s    = 1'b0;
      if (!reset) begin
         state_nxt_s = RUN;
      end else begin
         case (state_r)
            RUN: begin
               en_s = EN_ALL;
               if (mem_op_s) begin
                  req_s = 1'b1;
                  // Zero-wait access when ack arrives with the request.
                  if (!bus.dmem_ack) begin
                     en_s        = EN_NONE;
                     state_nxt_s = MEM_WAIT;
                     wcnt_nxt_s  = WCNT_W'(1);
                  end else begin
                     en_s = EN_ALL;
                  end
               end else if (taken_s) begin
                  if_id_flush_s  = 1'b1;
                  id_ex_flush_s  = 1'b1;
                  ex_mem_flush_s = 1'b1;
               end else if (hazard_s) begin
                  // Hold PC and IF_ID one cycle and inject a bubble into ID_EX.
                  en_s.pc       = 1'b0;
                  en_s.if_id    = 1'b0;
                  id_ex_flush_s = 1'b1;
               end else begin
                  en_s = EN_ALL;
               end
            end
            MEM_WAIT: begin
               req_s = 1'b1;
               if (bus.dmem_ack) begin
                  en_s        = EN_ALL;
                  state_nxt_s = RUN;
                  wcnt_nxt_s  = '0;
               end else if (wcnt_r == WCNT_W'(TIMEOUT)) begin
                  state_nxt_s       = ERROR;
                  timeout_err_nxt_s = 1'b1;
               end else begin
                  wcnt_nxt_s = wcnt_r + WCNT_W'(1);
               end
            end
            ERROR: begin
               timeout_err_nxt_s = 1'b1;
            end
            default: begin
               state_nxt_s = RUN;
               wcnt_nxt_s  = '0;
            end
         endcase
      end
   end

   // State, wait counter and sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r       <= RUN;
         wcnt_r        <= '0;
         timeout_err_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         wcnt_r        <= wcnt_nxt_s;
         timeout_err_r <= timeout_err_nxt_s;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_r <= '0;
      end else if (!en_s.pc && (stall_cycles_r != {CNT_W{1'b1}})) begin
         stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign bus.dmem_req     = req_s;
   assign bus.PC_write     = en_s.pc;
   assign bus.IF_ID_write  = en_s.if_id;
   assign bus.ID_EX_write  = en_s.id_ex;
   assign bus.EX_MEM_write = en_s.ex_mem;
   assign bus.MEM_WB_write = en_s.mem_wb;
   assign bus.IF_ID_flush  = if_id_flush_s;
   assign bus.ID_EX_flush  = id_ex_flush_s;
   assign bus.EX_MEM_flush = ex_mem_flush_s;
   assign bus.timeout_err  = timeout_err_r;
   assign bus.stall_cycles = stall_cycles_r;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipe_hazard_ctrl;
   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int SMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

   pipe_hazard_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 = running, 1 = waiting for memory, 2 = dead after timeout.
   int m_mode   = 0;
   int m_waited = 0;
   int m_stall  = 0;
   bit m_terr   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] obs_vec();
      return {bus.dmem_req, bus.PC_write, bus.IF_ID_write, bus.ID_EX_write,
              bus.EX_MEM_write, bus.MEM_WB_write, bus.IF_ID_flush,
              bus.ID_EX_flush, bus.EX_MEM_flush};
   endfunction

   // Expected {req, enables[4:0], flushes[2:0]} from the architectural rules.
   function automatic logic [8:0] model_out();
      bit mem, taken, haz;
      mem   = bus.MemRead_MEM || bus.MemWrite_MEM;
      taken = bus.Branch_MEM && bus.ZERO_MEM;
      haz   = bus.MemRead_EX && (bus.RD_EX != 0) &&
              (bus.RD_EX == bus.RS1_ID || bus.RD_EX == bus.RS2_ID);
      if (!reset)      return 9'b0_00000_000;
      if (m_mode == 2) return 9'b0_00000_000;
      if (m_mode == 1) return bus.dmem_ack ? 9'b1_11111_000 : 9'b1_00000_000;
      if (mem)         return bus.dmem_ack ? 9'b1_11111_000 : 9'b1_00000_000;
      if (taken)       return 9'b0_11111_111;
      if (haz)         return 9'b0_00111_010;
      return 9'b0_11111_000;
   endfunction

   task automatic model_advance(input bit pc_en);
      bit mem;
      mem = bus.MemRead_MEM || bus.MemWrite_MEM;
      if (!pc_en && m_stall < SMAX) m_stall++;
      if (m_mode == 0) begin
         if (mem && !bus.dmem_ack) begin
            m_mode   = 1;
            m_waited = 1;
         end
      end else if (m_mode == 1) begin
         if (bus.dmem_ack) m_mode = 0;
         else if (m_waited == TMO) begin
            m_mode = 2;
            m_terr = 1'b1;
         end else m_waited++;
      end
   endtask

   // Called at posedge+1 with inputs already set; returns at next posedge+1.
   task automatic step(input string tag);
      logic [8:0] e;
      #2;
      e = model_out();
      check_val(tag, {23'd0, obs_vec()}, {23'd0, e});
      @(posedge clk);
      #1;
      model_advance(e[7]);
      check_val({tag, "_stall"}, {28'd0, bus.stall_cycles}, m_stall);
      check_val({tag, "_terr"}, {31'd0, bus.timeout_err}, {31'd0, m_terr});
   endtask

   task automatic set_in(input bit mre, input int rd, input int r1, input int r2,
                         input bit br, input bit z, input bit mrm, input bit mwm, input bit ack);
      bus.MemRead_EX   = mre;
      bus.RD_EX        = 5'(rd);
      bus.RS1_ID       = 5'(r1);
      bus.RS2_ID       = 5'(r2);
      bus.Branch_MEM   = br;
      bus.ZERO_MEM     = z;
      bus.MemRead_MEM  = mrm;
      bus.MemWrite_MEM = mwm;
      bus.dmem_ack     = ack;
   endtask

   // Asynchronous reset pulse at the current time; ends aligned at posedge+1.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check_val({tag, "_out"}, {23'd0, obs_vec()}, 32'd0);
      check_val({tag, "_stall"}, {28'd0, bus.stall_cycles}, 32'd0);
      check_val({tag, "_terr"}, {31'd0, bus.timeout_err}, 32'd0);
      m_mode = 0; m_waited = 0; m_stall = 0; m_terr = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dead;
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_out", {23'd0, obs_vec()}, 32'd0);
      check_val("rst_stall", {28'd0, bus.stall_cycles}, 32'd0);
      check_val("rst_terr", {31'd0, bus.timeout_err}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Load-use on RS2: one bubble, then clear.
      set_in(1, 5, 0, 5, 0, 0, 0, 0, 0); step("lu");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("lu_after");
      // Load into x0 never stalls.
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); step("lu_x0");
      // Taken branch overrides load-use.
      set_in(1, 5, 5, 0, 1, 1, 0, 0, 0); step("br_taken");
      set_in(1, 5, 5, 0, 1, 0, 0, 0, 0); step("br_not_taken");
      // Load in MEM, ack after three stalled cycles.
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (3) step("ld_wait");
      bus.dmem_ack = 1'b1; step("ld_ack");
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step("ack_idle");
      // Zero-wait store.
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); step("st_zw");
      // Store never acknowledged: timeout into ERROR.
      set_in(1, 3, 3, 3, 1, 1, 0, 1, 0);
      repeat (8) step("st_tmo");
      do_reset("tmo_rst");
      // Asynchronous reset in the middle of a wait.
      set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (2) step("ld_pre_rst");
      #2;
      do_reset("mid_rst");

      // Randomized traffic.
      dead = 0;
      for (int i = 0; i < 600; i++) begin
         bit ack;
         ack = (m_mode == 1) ? ($urandom_range(1, 0) == 1) : ($urandom_range(4, 0) == 0);
         set_in($urandom_range(1, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                $urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, ack);
         if (m_mode == 2) dead++;
         if (dead > 3 || $urandom_range(199, 0) == 0) begin
            dead = 0;
            #($urandom_range(3, 1));
            do_reset("rnd_rst");
         end else begin
            step("rnd");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
